// File: rtl/data_mem_ctrl_if.sv
// Datapath-side and memory-side signal bundle of the data-memory access controller.
interface data_mem_ctrl_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              req;
    logic              we;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       wdata;
    logic [63:0]       rdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic              mem_wr;
    logic [63:0]       mem_rdata;

    modport master (
        output req, we, funct3, addr, wdata, mem_rdata,
        input  rdata, busy, done, err, mem_addr, mem_wdata, mem_wr
    );

    modport slave (
        input  req, we, funct3, addr, wdata, mem_rdata,
        output rdata, busy, done, err, mem_addr, mem_wdata, mem_wr
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Multicycle RV64 load/store controller: lane extraction, sign/zero extension, RMW sub-doubleword stores.
// Optional macro MISALIGN_TRAP_EN: misaligned accesses complete with err instead of being force-aligned.
module data_mem_ctrl #(
    parameter int unsigned ADDR_W = 64
) (
    input  logic            clk,
    input  logic            reset,
    data_mem_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, RD, LDX, MRG, WR, DONE} state_t;

    state_t            state;
    state_t            stateNext;
    logic [ADDR_W-1:0] addrQ;
    logic              weQ;
    logic [2:0]        funct3Q;
    logic [63:0]       wdataQ;
    logic [63:0]       rdataQ;
    logic              busyQ;
    logic              doneQ;
    logic              errQ;

    logic              illegal;
    logic              accessErr;
    logic [2:0]        offEff;
    logic [5:0]        laneShift;
    logic [63:0]       sizeMask;
    logic [63:0]       laneMask;
    logic [63:0]       shifted;
    logic [63:0]       loadVal;
    logic [63:0]       mergeVal;
    logic [63:0]       memWdata;
    logic              memWr;

    // Legality of the live request, evaluated at acceptance
`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    always_comb begin
        illegal = bus.we ? bus.funct3[2] : (bus.funct3 == 3'b111);
        case (bus.funct3[1:0])
            2'd1:    misaligned = bus.addr[0];
            2'd2:    misaligned = |bus.addr[1:0];
            2'd3:    misaligned = |bus.addr[2:0];
            default: misaligned = 1'b0;
        endcase
        accessErr = illegal | misaligned;
    end
`else
    always_comb begin
        illegal   = bus.we ? bus.funct3[2] : (bus.funct3 == 3'b111);
        accessErr = illegal;
    end
`endif

    // Offset bits below the access size are dropped so every lane fits in the doubleword
    always_comb begin
        case (funct3Q[1:0])
            2'd0:    begin offEff = addrQ[2:0];              sizeMask = 64'h0000_0000_0000_00FF; end
            2'd1:    begin offEff = {addrQ[2:1], 1'b0};      sizeMask = 64'h0000_0000_0000_FFFF; end
            2'd2:    begin offEff = {addrQ[2], 2'b00};       sizeMask = 64'h0000_0000_FFFF_FFFF; end
            default: begin offEff = 3'b000;                  sizeMask = 64'hFFFF_FFFF_FFFF_FFFF; end
        endcase
        laneShift = {offEff, 3'b000};
        laneMask  = sizeMask << laneShift;
        shifted   = bus.mem_rdata >> laneShift;
        mergeVal  = (bus.mem_rdata & ~laneMask) | ((wdataQ << laneShift) & laneMask);
        case (funct3Q)
            3'b000:  loadVal = {{56{shifted[7]}},  shifted[7:0]};
            3'b001:  loadVal = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  loadVal = {{32{shifted[31]}}, shifted[31:0]};
            3'b100:  loadVal = {56'd0, shifted[7:0]};
            3'b101:  loadVal = {48'd0, shifted[15:0]};
            3'b110:  loadVal = {32'd0, shifted[31:0]};
            default: loadVal = shifted;
        endcase
    end

    // Next-state and memory write strobe
    always_comb begin
        stateNext = state;
        memWr     = 1'b0;
        memWdata  = '0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (accessErr)                            stateNext = DONE;
                    else if (bus.we && bus.funct3 == 3'b011)  stateNext = WR;
                    else                                      stateNext = RD;
                end
            end
            RD:   stateNext = weQ ? MRG : LDX;
            LDX:  stateNext = DONE;
            MRG: begin
                memWr     = 1'b1;
                memWdata  = mergeVal;
                stateNext = DONE;
            end
            WR: begin
                memWr     = 1'b1;
                memWdata  = wdataQ;
                stateNext = DONE;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            addrQ   <= '0;
            weQ     <= 1'b0;
            funct3Q <= '0;
            wdataQ  <= '0;
            rdataQ  <= '0;
            busyQ   <= 1'b0;
            doneQ   <= 1'b0;
            errQ    <= 1'b0;
        end else begin
            state <= stateNext;
            busyQ <= (stateNext != IDLE);
            doneQ <= (stateNext == DONE);
            errQ  <= (state == IDLE) && bus.req && accessErr;
            if (state == IDLE && bus.req) begin
                addrQ   <= bus.addr;
                weQ     <= bus.we;
                funct3Q <= bus.funct3;
                wdataQ  <= bus.wdata;
            end
            if (state == LDX) rdataQ <= loadVal;
        end
    end

    assign bus.rdata     = rdataQ;
    assign bus.busy      = busyQ;
    assign bus.done      = doneQ;
    assign bus.err       = errQ;
    assign bus.mem_wr    = memWr;
    assign bus.mem_wdata = memWdata;
    assign bus.mem_addr  = (state == IDLE) ? {bus.addr[ADDR_W-1:3], 3'b000}
                                           : {addrQ[ADDR_W-1:3], 3'b000};
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus randomized accesses against a byte-level model.
module tb_data_mem_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    data_mem_ctrl_if #(.ADDR_W(64)) bus();
    data_mem_ctrl #(.ADDR_W(64)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Synchronous 16-doubleword memory, cleared while reset is low
    logic [63:0] mem [16];
    int          wrCount = 0;
    logic [63:0] lastWrAddr = '0;
    logic [63:0] lastWrData = '0;
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (bus.mem_wr) begin
            mem[bus.mem_addr[6:3]] <= bus.mem_wdata;
            wrCount    <= wrCount + 1;
            lastWrAddr <= bus.mem_addr;
            lastWrData <= bus.mem_wdata;
        end
        bus.mem_rdata <= mem[bus.mem_addr[6:3]];
    end

    // Reference model state
    logic [63:0] mdl [16];
    logic [63:0] rdataExp;

    function automatic logic [63:0] expLoad(logic [63:0] d, logic [2:0] f, int off);
        logic [63:0] v;
        int size;
        size = 1 << f[1:0];
        v = '0;
        for (int i = 0; i < size; i++) v[i*8 +: 8] = d[(off+i)*8 +: 8];
        if (!f[2] && size < 8 && v[size*8-1])
            for (int i = size; i < 8; i++) v[i*8 +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [63:0] expMerge(logic [63:0] old, logic [63:0] d, int off, int size);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < size; i++) r[(off+i)*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    // Drives one request, returns observations at the done pulse, then steps back to IDLE
    task automatic doAccess(input logic w, input logic [2:0] f, input logic [63:0] a, input logic [63:0] d,
                            output int lat, output int busyCnt, output int nWr,
                            output logic e, output logic [63:0] rd);
        int w0;
        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.funct3 = f; bus.addr = a; bus.wdata = d;
        w0 = wrCount;
        @(posedge clk); #1;
        bus.req = 1'b0; bus.we = 1'($urandom); bus.funct3 = 3'($urandom);
        bus.addr = 64'($urandom_range(0, 127)); bus.wdata = {$urandom, $urandom};
        lat = 99; busyCnt = 0; e = 1'b0; rd = '0;
        for (int k = 1; k <= 12; k++) begin
            if (bus.busy) busyCnt++;
            if (bus.done) begin lat = k; e = bus.err; rd = bus.rdata; break; end
            @(posedge clk); #1;
        end
        nWr = wrCount - w0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int lat, bc, nw; logic e; logic [63:0] rd;
        doAccess(1'b1, 3'b011, 64'h8, 64'h0123_4567_89AB_CDEF, lat, bc, nw, e, rd);
        doAccess(1'b0, 3'b011, 64'h8, 64'h0, lat, bc, nw, e, rd);
        checks++;
        if (rd !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL pre_reset_ld got=%h exp=%h", rd, 64'h0123_4567_89AB_CDEF); end
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = 3'b011; bus.addr = 64'h8;
        @(posedge clk); #1;
        bus.req = 1'b0; bus.addr = '0;
        reset = 1'b0; #1;
        checks++;
        if ({bus.rdata, bus.busy, bus.done, bus.err, bus.mem_wr, bus.mem_wdata, bus.mem_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs rdata=%h busy=%b done=%b err=%b wr=%b wdata=%h maddr=%h exp=all_zero",
                     bus.rdata, bus.busy, bus.done, bus.err, bus.mem_wr, bus.mem_wdata, bus.mem_addr);
        end
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = 3'b011; bus.addr = 64'h8;
        @(posedge clk); #1;
        bus.req = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL accept_after_reset busy=%b exp=1", bus.busy); end
        lat = 99;
        for (int k = 1; k <= 8; k++) begin
            if (bus.done) begin lat = k; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (lat != 3) begin errors++; $display("FAIL post_reset_latency got=%0d exp=3", lat); end
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        rdataExp = '0;
    endtask

    task automatic test_sd();
        int lat, bc, nw; logic e; logic [63:0] rd;
        doAccess(1'b1, 3'b011, 64'h10, 64'h1122_3344_5566_7788, lat, bc, nw, e, rd);
        checks++; if (lat != 2) begin errors++; $display("FAIL sd_latency got=%0d exp=2", lat); end
        checks++; if (bc != 2) begin errors++; $display("FAIL sd_busy_cycles got=%0d exp=2", bc); end
        checks++; if (nw != 1) begin errors++; $display("FAIL sd_writes got=%0d exp=1", nw); end
        checks++; if (lastWrAddr !== 64'h10) begin errors++; $display("FAIL sd_addr got=%h exp=%h", lastWrAddr, 64'h10); end
        checks++; if (lastWrData !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL sd_data got=%h exp=1122334455667788", lastWrData); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL sd_err got=%b exp=0", e); end
        mdl[2] = 64'h1122_3344_5566_7788;
    endtask

    task automatic test_loads();
        int lat, bc, nw; logic e; logic [63:0] rd;
        logic [2:0]  f3s [3];
        logic [63:0] exps [3];
        f3s[0] = 3'b000; exps[0] = 64'hFFFF_FFFF_FFFF_FF80;
        f3s[1] = 3'b100; exps[1] = 64'h0000_0000_0000_0080;
        f3s[2] = 3'b001; exps[2] = 64'hFFFF_FFFF_FFFF_F080;
        doAccess(1'b1, 3'b011, 64'h10, 64'h0000_0000_0000_F080, lat, bc, nw, e, rd);
        mdl[2] = 64'h0000_0000_0000_F080;
        for (int i = 0; i < 3; i++) begin
            doAccess(1'b0, f3s[i], 64'h10, 64'h0, lat, bc, nw, e, rd);
            checks++; if (rd !== exps[i]) begin errors++; $display("FAIL load_f3_%0d got=%h exp=%h", f3s[i], rd, exps[i]); end
            checks++; if (lat != 3) begin errors++; $display("FAIL load_latency_f3_%0d got=%0d exp=3", f3s[i], lat); end
            checks++; if (nw != 0) begin errors++; $display("FAIL load_writes got=%0d exp=0", nw); end
            rdataExp = exps[i];
        end
    endtask

    task automatic test_sb();
        int lat, bc, nw; logic e; logic [63:0] rd;
        doAccess(1'b1, 3'b011, 64'h18, 64'hAAAA_AAAA_AAAA_AAAA, lat, bc, nw, e, rd);
        doAccess(1'b1, 3'b000, 64'h1B, 64'h55, lat, bc, nw, e, rd);
        checks++; if (lastWrData !== 64'hAAAA_AAAA_55AA_AAAA) begin errors++; $display("FAIL sb_merge got=%h exp=AAAAAAAA55AAAAAA", lastWrData); end
        checks++; if (nw != 1) begin errors++; $display("FAIL sb_writes got=%0d exp=1", nw); end
        checks++; if (lat != 3) begin errors++; $display("FAIL sb_latency got=%0d exp=3", lat); end
        checks++; if (rd !== rdataExp) begin errors++; $display("FAIL sb_rdata_hold got=%h exp=%h", rd, rdataExp); end
        mdl[3] = 64'hAAAA_AAAA_55AA_AAAA;
    endtask

    task automatic test_illegal();
        int lat, bc, nw; logic e; logic [63:0] rd;
        for (int i = 0; i < 2; i++) begin
            doAccess(i == 1, (i == 1) ? 3'b100 : 3'b111, 64'h18, 64'hFFFF, lat, bc, nw, e, rd);
            checks++; if (lat != 1) begin errors++; $display("FAIL illegal%0d_latency got=%0d exp=1", i, lat); end
            checks++; if (e !== 1'b1) begin errors++; $display("FAIL illegal%0d_err got=%b exp=1", i, e); end
            checks++; if (nw != 0) begin errors++; $display("FAIL illegal%0d_writes got=%0d exp=0", i, nw); end
            checks++; if (rd !== rdataExp) begin errors++; $display("FAIL illegal%0d_rdata got=%h exp=%h", i, rd, rdataExp); end
        end
    endtask

    task automatic test_misalign();
        int lat, bc, nw; logic e; logic [63:0] rd;
        doAccess(1'b0, 3'b010, 64'h12, 64'h0, lat, bc, nw, e, rd);
`ifdef MISALIGN_TRAP_EN
        checks++; if (e !== 1'b1 || lat != 1) begin errors++; $display("FAIL lw_misalign err=%b lat=%0d exp err=1 lat=1", e, lat); end
        checks++; if (rd !== rdataExp) begin errors++; $display("FAIL lw_misalign_rdata got=%h exp=%h", rd, rdataExp); end
`else
        rdataExp = expLoad(mdl[2], 3'b010, 0);
        checks++; if (e !== 1'b0 || lat != 3) begin errors++; $display("FAIL lw_aligned err=%b lat=%0d exp err=0 lat=3", e, lat); end
        checks++; if (rd !== rdataExp) begin errors++; $display("FAIL lw_aligned_rdata got=%h exp=%h", rd, rdataExp); end
`endif
    endtask

    task automatic test_back_to_back();
        int doneAt [2];
        int nDone = 0;
        logic idleSeen = 1'b0;
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = 3'b011; bus.addr = 64'h18;
        @(posedge clk); #1;
        doneAt[0] = 0; doneAt[1] = 0;
        for (int k = 1; k <= 8; k++) begin
            if (bus.done) begin
                if (nDone < 2) doneAt[nDone] = k;
                nDone++;
            end
            if (k == 4) idleSeen = !bus.busy;
            if (k == 5) bus.req = 1'b0;
            @(posedge clk); #1;
        end
        rdataExp = mdl[3];
        checks++; if (nDone != 2 || doneAt[0] != 3 || doneAt[1] != 7) begin
            errors++; $display("FAIL b2b_done count=%0d at=%0d,%0d exp count=2 at=3,7", nDone, doneAt[0], doneAt[1]); end
        checks++; if (!idleSeen) begin errors++; $display("FAIL b2b_idle_gap busy_at_4=1 exp=0"); end
        checks++; if (bus.rdata !== rdataExp) begin errors++; $display("FAIL b2b_rdata got=%h exp=%h", bus.rdata, rdataExp); end
    endtask

    task automatic test_random();
        int lat, bc, nw, size, o, offE, idx, expLat;
        logic e, expErr, illegal, mis, w;
        logic [2:0] f;
        logic [63:0] a, d, rd, nv;
        for (int n = 0; n < 200; n++) begin
            w = 1'($urandom);
            f = 3'($urandom);
            a = 64'($urandom_range(0, 127));
            d = {$urandom, $urandom};
            size = 1 << f[1:0];
            o = int'(a % 8);
            idx = int'(a / 8);
            illegal = w ? (f >= 3'd4) : (f == 3'd7);
            mis = (o % size) != 0;
`ifdef MISALIGN_TRAP_EN
            expErr = illegal || mis;
`else
            expErr = illegal;
`endif
            offE = o - (o % size);
            expLat = expErr ? 1 : (w && size == 8) ? 2 : 3;
            doAccess(w, f, a, d, lat, bc, nw, e, rd);
            if (!expErr && !w) rdataExp = expLoad(mdl[idx], f, offE);
            checks++;
            if (lat != expLat || bc != expLat || e !== expErr || nw != ((!expErr && w) ? 1 : 0) || rd !== rdataExp) begin
                errors++;
                $display("FAIL rand%0d we=%b f3=%0d addr=%h got lat=%0d busy=%0d err=%b wr=%0d rdata=%h exp lat=%0d err=%b rdata=%h",
                         n, w, f, a, lat, bc, e, nw, rd, expLat, expErr, rdataExp);
            end
            if (!expErr && w) begin
                nv = expMerge(mdl[idx], d, offE, size);
                checks++;
                if (lastWrData !== nv || lastWrAddr !== 64'(idx * 8)) begin
                    errors++;
                    $display("FAIL rand%0d_store got addr=%h data=%h exp addr=%h data=%h", n, lastWrAddr, lastWrData, 64'(idx * 8), nv);
                end
                mdl[idx] = nv;
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = '0; bus.addr = '0; bus.wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_sd();
        test_loads();
        test_sb();
        test_illegal();
        test_misalign();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Multicycle data-memory access controller between the processor datapath (ALUOut address, B register store data, control-unit strobes) and the 64-bit synchronous data memory. It performs RV64 loads (LB/LH/LW/LD/LBU/LHU/LWU) with byte-lane extraction and sign or zero extension. Sub-doubleword stores (SB/SH/SW) are done by read-modify-write; SD is a direct write. The loaded value is held in an internal register for the register-file write-data mux, replacing the bare memory-data register.

## Interface
Parameters:
- ADDR_W, 64: width of the byte address from the datapath.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = store, 0 = load; sampled with req.
- funct3  in  3  RISC-V size/sign code; sampled with req.
- addr  in  ADDR_W  byte address; sampled with req.
- wdata  in  64  store data, right-aligned; sampled with req.
- rdata  out  64  extended load result; holds until the next load completes.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when an access completes.
- err  out  1  one-cycle pulse with done on an illegal or misaligned access.
- mem_addr  out  ADDR_W  doubleword-aligned address, {addr[ADDR_W-1:3],3'b000}.
- mem_wdata  out  64  merged write doubleword.
- mem_wr  out  1  memory write strobe, one cycle.
- mem_rdata  in  64  memory read data, valid one cycle after mem_addr is stable.

## Operation
- On acceptance (req=1 in IDLE), addr, we, funct3 and wdata are latched. Inputs are ignored afterwards until the next IDLE.
- Byte offset is off = addr[2:0]. Lane shift is off*8 bits.
- States and transitions:
  - IDLE → RD when req and (load, or store with funct3 ∈ {000,001,010}).
  - IDLE → WR when req and store with funct3 = 011.
  - IDLE → DONE with err when funct3 is illegal: 111 for a load, or ≥100 for a store.
  - RD → MRG if store, else → LDX.
  - LDX: capture mem_rdata >> lane shift, extend to 64 bits into rdata, → DONE.
  - MRG: mem_wdata = mem_rdata with the sized lanes replaced by wdata << lane shift; mem_wr=1; → DONE.
  - WR: mem_wdata = wdata, mem_wr=1, → DONE.
  - DONE: done=1, → IDLE.
- Sign extension:
  - funct3 000/001/010: sign-extend from bit 7/15/31.
  - 100/101/110: zero-extend from the same widths.
  - 011: no extension.
- An errored access performs no mem_wr and leaves rdata unchanged.
- mem_addr is driven from the latched address in all non-IDLE states. It is driven from the live addr in IDLE.

## Timing
- Reset (reset=0, asynchronous): state=IDLE; rdata=0, busy=0, done=0, err=0, mem_wr=0, mem_wdata=0, mem_addr=0 (latched address cleared).
- Latency from the accepting edge to the done pulse:
  - Load: 3 cycles (RD, LDX, DONE).
  - Sub-doubleword store: 3 cycles (RD, MRG, DONE).
  - SD: 2 cycles (WR, DONE).
  - Illegal access: 1 cycle.
- rdata is updated on the LDX→DONE edge and is valid in the same cycle done is high.
- req held high through DONE does not start a new access until the cycle after DONE, when the state is IDLE again. The maximum issue rate is one access per latency+1 cycles.
- Reset asserted mid-access aborts it immediately. A pending MRG/WR write is not performed if reset falls before that edge.

## Configuration
- MISALIGN_TRAP_EN defined:
  - Misalignment is a half access with addr[0]≠0, a word access with addr[1:0]≠0, or a doubleword access with addr[2:0]≠0.
  - A misaligned access goes IDLE → DONE with err=1, no memory write, and rdata unchanged.
- MISALIGN_TRAP_EN undefined:
  - The low offset bits below the access size are forced to 0 (off & ~(size-1)) and the access proceeds normally.
  - err is raised only for illegal funct3.

## Test plan
- Reset low mid-RD → all outputs 0 and state IDLE. After release, a req is accepted on the first edge.
- SD addr=0x10, wdata=0x1122334455667788 → mem_wr pulses once with mem_addr=0x10. done 2 cycles after acceptance; busy high for exactly 2 cycles.
- Memory word 0x10 = 0x00000000_0000F080; LB addr=0x10 → rdata=0xFFFFFFFFFFFFFF80. LBU addr=0x10 → 0x80. LH addr=0x10 → 0xFFFFFFFFFFFFF080. Each has done at +3 cycles.
- Memory word 0x18 = 0xAAAAAAAAAAAAAAAA; SB addr=0x1B wdata=0x55 → mem_wdata=0xAAAAAAAA55AAAAAA, one mem_wr, done at +3.
- funct3=111 load, or funct3=100 store → done and err together 1 cycle after acceptance, no mem_wr, rdata unchanged.
- LW addr=0x12 → with MISALIGN_TRAP_EN: err=1, no memory read result. Without it: access at offset 0, rdata = sign-extended low word of doubleword 0x10.
